dp_issue: RTL and testbench



---
 rtl/dp_pkg.sv | 70 +++++++
 rtl/dp_issue_if.sv | 32 +++
 rtl/dp_issue.sv | 74 +++++++
 tb/tb_dp_issue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the datapath control word: field map, widths,
// the unpacked control struct and the instruction decoder.
package dp_pkg;

    localparam int unsigned IW     = 40;
    localparam int unsigned NREG   = 16;
    localparam int unsigned RIDX_W = $clog2(NREG);
    localparam int unsigned OP_W   = 3;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned REP_W  = 4;
    localparam int unsigned ZR_W   = 4;
    localparam int unsigned WR_W   = 2;

    localparam int unsigned REP_MSB  = 39;
    localparam int unsigned REP_LSB  = 36;
    localparam int unsigned ZR_MSB   = 35;
    localparam int unsigned ZR_LSB   = 32;
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 29;
    localparam int unsigned FORM_BIT = 28;
    localparam int unsigned VEC_MSB  = 27;
    localparam int unsigned VEC_LSB  = 26;
    localparam int unsigned A_MSB    = 25;
    localparam int unsigned A_LSB    = 22;
    localparam int unsigned B_MSB    = 21;
    localparam int unsigned B_LSB    = 18;
    localparam int unsigned C_MSB    = 17;
    localparam int unsigned C_LSB    = 14;
    localparam int unsigned D_MSB    = 13;
    localparam int unsigned D_LSB    = 10;
    localparam int unsigned Y1_MSB   = 9;
    localparam int unsigned Y1_LSB   = 6;
    localparam int unsigned Y2_MSB   = 5;
    localparam int unsigned Y2_LSB   = 2;
    localparam int unsigned WR_MSB   = 1;
    localparam int unsigned WR_LSB   = 0;

    typedef struct packed {
        logic [REP_W-1:0]  rep;
        logic [ZR_W-1:0]   zero_reg;
        logic [OP_W-1:0]   op;
        logic              form;
        logic [VEC_W-1:0]  vec;
        logic [RIDX_W-1:0] a;
        logic [RIDX_W-1:0] b;
        logic [RIDX_W-1:0] c;
        logic [RIDX_W-1:0] d;
        logic [RIDX_W-1:0] y1;
        logic [RIDX_W-1:0] y2;
        logic [WR_W-1:0]   write;
    } dp_ctrl_t;

    function automatic dp_ctrl_t dp_unpack(input logic [IW-1:0] instr);
        dp_ctrl_t c;
        c.rep      = instr[REP_MSB:REP_LSB];
        c.zero_reg = instr[ZR_MSB:ZR_LSB];
        c.op       = instr[OP_MSB:OP_LSB];
        c.form     = instr[FORM_BIT];
        c.vec      = instr[VEC_MSB:VEC_LSB];
        c.a        = instr[A_MSB:A_LSB];
        c.b        = instr[B_MSB:B_LSB];
        c.c        = instr[C_MSB:C_LSB];
        c.d        = instr[D_MSB:D_LSB];
        c.y1       = instr[Y1_MSB:Y1_LSB];
        c.y2       = instr[Y2_MSB:Y2_LSB];
        c.write    = instr[WR_MSB:WR_LSB];
        return c;
    endfunction

endpackage

// File: rtl/dp_issue_if.sv
// Instruction handshake plus the datapath control bundle driven by dp_issue.
interface dp_issue_if;
    import dp_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [IW-1:0]       instr;
    logic                stall;
    logic [OP_W-1:0]     op;
    logic                form;
    logic [VEC_W-1:0]    vec;
    logic [RIDX_W-1:0]   A;
    logic [RIDX_W-1:0]   B;
    logic [RIDX_W-1:0]   C;
    logic [RIDX_W-1:0]   D;
    logic [RIDX_W-1:0]   Y1;
    logic [RIDX_W-1:0]   Y2;
    logic [ZR_W-1:0]     zero_reg;
    logic [WR_W-1:0]     write;
    logic                busy;

    modport slave (
        input  instr_valid, instr, stall,
        output instr_ready, op, form, vec, A, B, C, D, Y1, Y2, zero_reg, write, busy
    );

    modport master (
        output instr_valid, instr, stall,
        input  instr_ready, op, form, vec, A, B, C, D, Y1, Y2, zero_reg, write, busy
    );

endinterface

// File: rtl/dp_issue.sv
// Issue sequencer: accepts instruction words and replays each rep+1 times,
// stepping every register index by one per replay, onto the datapath controls.
module dp_issue
    import dp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    dp_issue_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e   r_state;
    state_e   w_state_nxt;
    // The rep field of the control register doubles as the remaining-replay count.
    dp_ctrl_t r_ctrl;
    dp_ctrl_t w_ctrl_nxt;
    logic     w_ready;
    logic     w_xfer;

    assign w_ready = rst_n & ~bus.stall & ((r_state == ST_IDLE) | (r_ctrl.rep == '0));
    assign w_xfer  = bus.instr_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        if (w_xfer) begin
            w_state_nxt = ST_ISSUE;
            w_ctrl_nxt  = dp_unpack(bus.instr);
        end else if (!bus.stall && (r_state == ST_ISSUE)) begin
            if (r_ctrl.rep != '0) begin
                w_ctrl_nxt.rep = r_ctrl.rep - REP_W'(1);
                w_ctrl_nxt.a   = r_ctrl.a  + RIDX_W'(1);
                w_ctrl_nxt.b   = r_ctrl.b  + RIDX_W'(1);
                w_ctrl_nxt.c   = r_ctrl.c  + RIDX_W'(1);
                w_ctrl_nxt.d   = r_ctrl.d  + RIDX_W'(1);
                w_ctrl_nxt.y1  = r_ctrl.y1 + RIDX_W'(1);
                w_ctrl_nxt.y2  = r_ctrl.y2 + RIDX_W'(1);
            end else begin
                w_state_nxt = ST_IDLE;
                w_ctrl_nxt  = '0;
            end
        end
    end

    // Control register is cleared in IDLE, so it drives the bubble directly.
    assign bus.instr_ready = w_ready;
    assign bus.busy        = (r_state == ST_ISSUE);
    assign bus.op          = r_ctrl.op;
    assign bus.form        = r_ctrl.form;
    assign bus.vec         = r_ctrl.vec;
    assign bus.A           = r_ctrl.a;
    assign bus.B           = r_ctrl.b;
    assign bus.C           = r_ctrl.c;
    assign bus.D           = r_ctrl.d;
    assign bus.Y1          = r_ctrl.y1;
    assign bus.Y2          = r_ctrl.y2;
    assign bus.zero_reg    = r_ctrl.zero_reg;
    assign bus.write       = r_ctrl.write & {WR_W{~bus.stall}};

endmodule

// File: tb/tb_dp_issue.sv
// Scoreboard bench for dp_issue: a queue-based issue model predicts each
// cycle's visible controls; a monitor pops one prediction per cycle.
module tb_dp_issue;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dp_issue_if bus();

    dp_issue u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]      zr;
        logic [2:0]      op;
        logic            form;
        logic [1:0]      vec;
        logic [5:0][3:0] idx;   // idx[5]=A .. idx[0]=Y2
        logic [1:0]      wr;
    } issue_t;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [1:0]  wr;
        logic [33:0] ctrl;
    } obs_t;

    issue_t pend[$];    // issue cycles still to be shown, head = currently visible
    obs_t   obs_q[$];   // expected observation per cycle
    int     n_chk  = 0;
    int     n_fail = 0;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] dut_ctrl();
        return {bus.zero_reg, bus.op, bus.form, bus.vec,
                bus.A, bus.B, bus.C, bus.D, bus.Y1, bus.Y2};
    endfunction

    function automatic logic [39:0] mk(input int rep, input int zr, input int op, input int form,
                                       input int vec, input int a, input int b, input int c,
                                       input int d, input int y1, input int y2, input int wr);
        return {4'(rep), 4'(zr), 3'(op), 1'(form), 2'(vec), 4'(a), 4'(b), 4'(c),
                4'(d), 4'(y1), 4'(y2), 2'(wr)};
    endfunction

    // One accepted word becomes rep+1 issue cycles with indices base+i mod 16.
    task automatic expand(input logic [39:0] w);
        issue_t it;
        int     rep;
        rep = int'(w[39:36]);
        for (int i = 0; i <= rep; i++) begin
            it.zr   = w[35:32];
            it.op   = w[31:29];
            it.form = w[28];
            it.vec  = w[27:26];
            for (int k = 0; k < 6; k++)
                it.idx[5-k] = 4'((int'(w[25-4*k -: 4]) + i) % 16);
            it.wr   = w[1:0];
            pend.push_back(it);
        end
    endtask

    // Apply inputs for the coming edge, advance the model, queue the expected view.
    task automatic step(input bit v, input logic [39:0] w, input bit s, output bit acc);
        obs_t o;
        bit   rdy;
        @(negedge clk);
        #1;
        bus.instr_valid = v;
        bus.instr       = w;
        bus.stall       = s;
        acc = 1'b0;
        if (!s) begin
            rdy = (pend.size() <= 1);
            if (pend.size() > 0) void'(pend.pop_front());
            if (v && rdy) begin
                acc = 1'b1;
                expand(w);
            end
        end
        o.busy  = (pend.size() > 0);
        o.ready = !s && (pend.size() <= 1);
        if (pend.size() > 0) begin
            o.wr   = s ? 2'b00 : pend[0].wr;
            o.ctrl = {pend[0].zr, pend[0].op, pend[0].form, pend[0].vec, pend[0].idx};
        end else begin
            o.wr   = 2'b00;
            o.ctrl = '0;
        end
        obs_q.push_back(o);
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            chk("busy",  40'(bus.busy),        40'(e.busy));
            chk("ready", 40'(bus.instr_ready), 40'(e.ready));
            chk("write", 40'(bus.write),       40'(e.wr));
            chk("ctrl",  40'(dut_ctrl()),      40'(e.ctrl));
        end
    end

    task automatic chk_quiet(input string tag, input logic exp_ready);
        chk({tag, "_busy"},  40'(bus.busy),        40'(0));
        chk({tag, "_ready"}, 40'(bus.instr_ready), 40'(exp_ready));
        chk({tag, "_write"}, 40'(bus.write),       40'(0));
        chk({tag, "_ctrl"},  40'(dut_ctrl()),      40'(0));
    endtask

    initial begin
        bit          acc;
        bit          v;
        bit          s;
        logic [39:0] w;
        int          guard;

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.stall       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_quiet("reset", 1'b0);
        rst_n = 1'b1;
        #1;
        chk_quiet("idle", 1'b1);

        // single issue
        step(1'b1, mk(0, 0, 5, 0, 0, 3, 0, 0, 0, 7, 0, 1), 1'b0, acc);
        repeat (3) step(1'b0, '0, 1'b0, acc);

        // replay with index wrap
        step(1'b1, mk(3, 0, 0, 0, 0, 14, 0, 0, 0, 0, 15, 2), 1'b0, acc);
        repeat (5) step(1'b0, '0, 1'b0, acc);

        // back-to-back words, second held until taken
        step(1'b1, mk(1, 5, 2, 1, 3, 1, 2, 3, 4, 5, 6, 3), 1'b0, acc);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            step(1'b1, mk(0, 9, 6, 0, 1, 8, 9, 10, 11, 12, 13, 1), 1'b0, acc);
            guard++;
        end
        chk("b2b_accept", 40'(acc), 40'(1));
        repeat (3) step(1'b0, '0, 1'b0, acc);

        // stall mid-replay
        step(1'b1, mk(2, 3, 1, 1, 2, 4, 5, 6, 7, 8, 9, 3), 1'b0, acc);
        repeat (2) step(1'b0, '0, 1'b1, acc);
        repeat (4) step(1'b0, '0, 1'b0, acc);

        // randomized traffic; an offered word is held until it is taken
        v   = 1'b0;
        acc = 1'b1;
        w   = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(v && !acc)) begin
                v = ($urandom_range(0, 9) < 6);
                w = {4'($urandom_range(0, 3)), 4'($urandom), 32'($urandom)};
                if ($urandom_range(0, 15) == 0) w[39:36] = 4'($urandom);
            end
            s = ($urandom_range(0, 4) == 0);
            step(v, w, s, acc);
        end
        repeat (20) step(1'b0, '0, 1'b0, acc);

        // async reset in the middle of a rep=5 sequence
        step(1'b1, mk(5, 10, 3, 1, 2, 1, 2, 3, 4, 5, 6, 3), 1'b0, acc);
        repeat (2) step(1'b0, '0, 1'b0, acc);
        @(negedge clk);
        #2;
        chk("pre_rst_write", 40'(bus.write), 40'(3));
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst", 1'b0);
        pend.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_quiet("post_rst", 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, acc);

        guard = 0;
        while (obs_q.size() > 0 && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("drain", 40'(obs_q.size()), 40'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
